// File: rtl/mod_n_counter.sv
// Cascaded mod-N up/down counter with parallel load, combinational tc, registered wrap/load_err pulses.
// Latency: q, wrap and load_err update one cycle after the edge; no backpressure, accepts a command every cycle.
module mod_n_counter #(
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4,
  parameter int DIGITS  = 2
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     up,
  input  logic                     load,
  input  logic [DIGITS*WIDTH-1:0]  d,
  output logic [DIGITS*WIDTH-1:0]  q,
  output logic                     tc,
  output logic                     wrap,
  output logic                     load_err
);

  localparam int              QW   = DIGITS * WIDTH;
  localparam logic [WIDTH-1:0] DMAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   DMOD = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  if (MODULUS < 2 || DIGITS < 1 || (64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_params
    $error("mod_n_counter: illegal MODULUS/WIDTH/DIGITS combination");
  end

  logic [QW-1:0]    cnt_nxt;
  logic [QW-1:0]    ld_val;
  logic             ld_bad;
  logic             all_max;
  logic             all_zero;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] din;

  always_comb begin
    cnt_nxt  = '0;
    ld_val   = '0;
    ld_bad   = 1'b0;
    all_max  = 1'b1;
    all_zero = 1'b1;
    cur      = '0;
    din      = '0;
    for (int k = 0; k < DIGITS; k++) begin
      cur = q[k*WIDTH +: WIDTH];
      // all_max/all_zero here still describe only the digits below k, i.e. the carry/borrow into k
      if (up && all_max)
        cnt_nxt[k*WIDTH +: WIDTH] = (cur == DMAX) ? '0 : cur + ONE;
      else if (!up && all_zero)
        cnt_nxt[k*WIDTH +: WIDTH] = (cur == '0) ? DMAX : cur - ONE;
      else
        cnt_nxt[k*WIDTH +: WIDTH] = cur;
      all_max  = all_max & (cur == DMAX);
      all_zero = all_zero & (cur == '0);

      din = d[k*WIDTH +: WIDTH];
      if ({1'b0, din} >= DMOD)
        ld_bad = 1'b1;
      else
        ld_val[k*WIDTH +: WIDTH] = din;
    end
  end

  assign tc = en & (up ? all_max : all_zero);

  always_ff @(posedge clk) begin
    if (!clr) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      q        <= ld_val;
      wrap     <= 1'b0;
      load_err <= ld_bad;
    end else if (en) begin
      q        <= cnt_nxt;
      wrap     <= tc;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: a default 10/4/2 instance and a 6/3/3 instance share control inputs,
// each checked against an integer-valued reference model (count value modulo MODULUS**DIGITS).
module tb_mod_n_counter;

  logic       clk = 1'b0;
  logic       clr, en, up, load;
  logic [7:0] d_a, q_a;
  logic [8:0] d_b, q_b;
  logic       tc_a, wrap_a, err_a, tc_b, wrap_b, err_b;

  int n_pass = 0, n_total = 0;
  int va = 0, vb = 0;
  bit wra = 0, era = 0, wrb = 0, erb = 0;
  int tc_seen_a, wrap_seen_a, first_wrap_b;

  always #5 clk = ~clk;

  mod_n_counter dut_a (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .d(d_a),
    .q(q_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a)
  );

  mod_n_counter #(.MODULUS(6), .WIDTH(3), .DIGITS(3)) dut_b (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .d(d_b),
    .q(q_b), .tc(tc_b), .wrap(wrap_b), .load_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Count value -> packed digits, least significant digit at bit 0.
  function automatic logic [31:0] pack(int v, int m, int w, int nd);
    logic [31:0] r = '0;
    for (int k = 0; k < nd; k++) begin
      r = r | (32'(v % m) << (k * w));
      v = v / m;
    end
    return r;
  endfunction

  // Packed load word -> count value, with out-of-range digits replaced by 0.
  function automatic int decode(logic [31:0] dv, int m, int w, int nd, output bit bad);
    int val = 0, mult = 1, dig;
    bad = 1'b0;
    for (int k = 0; k < nd; k++) begin
      dig = int'((dv >> (k * w)) & ((32'd1 << w) - 1));
      if (dig >= m) begin
        bad = 1'b1;
        dig = 0;
      end
      val  = val + dig * mult;
      mult = mult * m;
    end
    return val;
  endfunction

  task automatic model(inout int v, inout bit wr, inout bit er, input int m, input int w,
                       input int nd, input logic [31:0] dv, input bit c, input bit e,
                       input bit u, input bit l, input bit tcx);
    int  n = m ** nd;
    bit  bad;
    if (!c) begin
      v = 0; wr = 0; er = 0;
    end else if (l) begin
      v = decode(dv, m, w, nd, bad); wr = 0; er = bad;
    end else if (e) begin
      wr = tcx; er = 0;
      v  = u ? (v + 1) % n : (v + n - 1) % n;
    end else begin
      wr = 0; er = 0;
    end
  endtask

  task automatic step(input bit c, input bit e, input bit u, input bit l,
                      input logic [7:0] da, input logic [8:0] db);
    bit tca, tcb;
    clr = c; en = e; up = u; load = l; d_a = da; d_b = db;
    @(negedge clk);
    tca = e && ((u && va == 99) || (!u && va == 0));
    tcb = e && ((u && vb == 215) || (!u && vb == 0));
    chk("tc_a", 32'(tc_a), 32'(tca));
    chk("tc_b", 32'(tc_b), 32'(tcb));
    if (tc_a === 1'b1) tc_seen_a++;
    @(posedge clk);
    model(va, wra, era, 10, 4, 2, 32'(da), c, e, u, l, tca);
    model(vb, wrb, erb, 6, 3, 3, 32'(db), c, e, u, l, tcb);
    #1;
    chk("q_a", 32'(q_a), pack(va, 10, 4, 2));
    chk("wrap_a", 32'(wrap_a), 32'(wra));
    chk("load_err_a", 32'(err_a), 32'(era));
    chk("q_b", 32'(q_b), pack(vb, 6, 3, 3));
    chk("wrap_b", 32'(wrap_b), 32'(wrb));
    chk("load_err_b", 32'(err_b), 32'(erb));
    if (wrap_a === 1'b1) wrap_seen_a++;
  endtask

  initial begin
    clr = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; d_a = 8'hFF; d_b = 9'h1FF;
    @(posedge clk); #1;
    chk("reset_q_a", 32'(q_a), 32'h0);
    chk("reset_wrap_a", 32'(wrap_a), 32'h0);
    chk("reset_err_a", 32'(err_a), 32'h0);
    chk("reset_q_b", 32'(q_b), 32'h0);
    chk("reset_wrap_b", 32'(wrap_b), 32'h0);
    chk("reset_err_b", 32'(err_b), 32'h0);

    // Full up cycle 00..99..00
    tc_seen_a = 0; wrap_seen_a = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 1, 1, 0, 8'h00, 9'($urandom));
      if (i == 98) chk("q_a_at_99", 32'(q_a), 32'h99);
      if (i == 99) chk("wrap_after_99_00", 32'(wrap_a), 32'h1);
    end
    chk("up_final_q_a", 32'(q_a), 32'h00);
    chk("up_tc_count", 32'(tc_seen_a), 32'd1);
    chk("up_wrap_count", 32'(wrap_seen_a), 32'd1);

    // Down wrap from 00
    step(1, 1, 0, 0, 8'h00, 9'($urandom));
    chk("down_q_99", 32'(q_a), 32'h99);
    chk("down_wrap", 32'(wrap_a), 32'h1);
    step(1, 1, 0, 0, 8'h00, 9'($urandom));
    chk("down_q_98", 32'(q_a), 32'h98);
    chk("down_wrap_clear", 32'(wrap_a), 32'h0);
    step(1, 1, 0, 0, 8'h00, 9'($urandom));
    chk("down_q_97", 32'(q_a), 32'h97);

    // Load then count; invalid-digit load
    step(1, 0, 1, 1, 8'h47, 9'($urandom));
    chk("load_47", 32'(q_a), 32'h47);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 8'h00, 9'($urandom));
    chk("count_50", 32'(q_a), 32'h50);
    chk("count_50_err", 32'(err_a), 32'h0);
    step(1, 0, 1, 1, 8'hA3, 9'($urandom));
    chk("load_a3_q", 32'(q_a), 32'h03);
    chk("load_a3_err", 32'(err_a), 32'h1);
    step(1, 0, 1, 0, 8'h00, 9'($urandom));
    chk("load_err_one_cycle", 32'(err_a), 32'h0);

    // Load beats count at terminal count; clr beats load
    step(1, 0, 1, 1, 8'h99, 9'($urandom));
    step(1, 1, 1, 1, 8'h12, 9'($urandom));
    chk("load_over_tc_q", 32'(q_a), 32'h12);
    chk("load_over_tc_wrap", 32'(wrap_a), 32'h0);
    step(0, 1, 1, 1, 8'hFF, 9'h1FF);
    chk("clr_over_load_q", 32'(q_a), 32'h00);
    chk("clr_over_load_err", 32'(err_a), 32'h0);

    // Hold, then per-cycle direction toggling
    step(1, 0, 1, 1, 8'h55, 9'($urandom));
    for (int i = 0; i < 5; i++) step(1, 0, 1'($urandom), 0, 8'($urandom), 9'($urandom));
    chk("hold_55", 32'(q_a), 32'h55);
    step(1, 1, 1, 0, 8'h00, 9'($urandom));
    chk("toggle_56", 32'(q_a), 32'h56);
    step(1, 1, 0, 0, 8'h00, 9'($urandom));
    chk("toggle_55", 32'(q_a), 32'h55);
    step(1, 1, 1, 0, 8'h00, 9'($urandom));
    chk("toggle_56b", 32'(q_a), 32'h56);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 7) == 0), 8'($urandom), 9'($urandom));

    // 6/3/3 instance: 555 -> 000 wrap after 216 up cycles
    step(0, 0, 1, 0, 8'h00, 9'h000);
    first_wrap_b = 0;
    for (int i = 0; i < 216; i++) begin
      step(1, 1, 1, 0, 8'h00, 9'($urandom));
      if (i == 214) chk("b_q_555", 32'(q_b), 32'o555);
      if (wrap_b === 1'b1 && first_wrap_b == 0) first_wrap_b = i + 1;
    end
    chk("b_wrap_cycle", 32'(first_wrap_b), 32'd216);
    chk("b_final_q", 32'(q_b), 32'h000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
